mc_seq: RTL
===========

// Module: mc_seq
// PURPOSE
//  Multi-cycle sequencer that sits between the combinational decoder (ctrl) and the datapath.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Handshakes with instruction and data memories, with a wait timeout on each.
//  Turns ctrl's level write enables (RFWr/DMWr) into phase-gated, single-retire strobes, and counts retired instructions.
// PARAMETERS
//  MEM_WAIT_MAX  15  last wait cycle (0-based) on which a late *_rdy is still accepted; rdy must arrive within MEM_WAIT_MAX+1 cycles
//  CNT_W         32  width of retired-instruction counter
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, synchronous, active-high
//  run        in   1      1 = keep issuing instructions; 0 = finish current instruction, then go IDLE
//  imem_req   out  1      instruction fetch request (level)
//  imem_rdy   in   1      fetch data valid this cycle
//  dmem_req   out  1      data memory access request (level)
//  dmem_rdy   in   1      data access complete this cycle
//  RFWr_i     in   1      from ctrl: instruction writes GPR
//  DMWr_i     in   1      from ctrl: instruction is a store
//  ld_i       in   1      from ctrl/decode: instruction is a load (WDSel==FromMem)
//  nop_i      in   1      decoded instruction is nop
//  except_i   in   1      from ctrl: NPCOp==NPC_EXCEPT (illegal opcode)
//  IRWr       out  1      latch instruction register
//  PCWr       out  1      commit NPC into PC (retire strobe)
//  RFWr       out  1      gated GPR write enable
//  DMWr       out  1      gated data memory write enable
//  mem_fault  out  1      sticky fault flag
//  state      out  3      current state encoding (debug)
//  instr_cnt  out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset: state=IDLE(0); wait_cnt=0; instr_cnt=0; mem_fault=0; all strobes/requests 0.
//  Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 FAULT=6; 7 unused -> FAULT.
//  IDLE:   run=1 -> FETCH; otherwise stay.
//  FETCH:  imem_req=1.
//    - imem_rdy=1: IRWr=1 that cycle -> DECODE.
//    - imem_rdy=0 and wait_cnt==MEM_WAIT_MAX -> FAULT; otherwise wait_cnt++.
//  DECODE: one cycle -> EXEC. ctrl outputs are valid from this state onward.
//  EXEC:   one cycle; checks in priority order:
//    1. except_i -> FAULT.
//    2. nop_i -> retire.
//    3. ld_i or DMWr_i -> MEM.
//    4. RFWr_i -> WB.
//    5. else (branch/j/jr) -> retire.
//  MEM:    dmem_req=1; DMWr=DMWr_i, held level for the whole state.
//    - dmem_rdy=1 and ld_i -> WB.
//    - dmem_rdy=1 and store -> retire.
//    - timeout rule as in FETCH -> FAULT.
//  WB:     RFWr=1 for exactly one cycle, then retire.
//  Retire (in EXEC, MEM or WB):
//    - PCWr=1 for one cycle; instr_cnt++ (wraps 2^CNT_W-1 -> 0).
//    - Next state: FETCH if run=1, else IDLE.
//  Register write-back order: jal's WB reads the old PC (PC+4 path) because PCWr and RFWr assert on the same edge.
//  wait_cnt clears on every entry to FETCH or MEM.
//  rdy arriving on the timeout cycle is accepted, i.e. rdy wins over fault.
//  FAULT:  mem_fault=1; all req/strobes 0; leaves only on rst.
//  rst has priority over everything, including mid-MEM; a pending store is dropped (DMWr=0 next cycle).
//  run is sampled only in IDLE and at retire; dropping it mid-instruction never aborts the instruction.
//  At most one of IRWr/PCWr/RFWr is high in any cycle, except PCWr+RFWr together in WB.
// TESTING
//  1. R-type: run=1, imem_rdy=1 always, RFWr_i=1.
//     -> FETCH, DECODE, EXEC, WB (4 cycles); RFWr=PCWr=1 in cycle 4; instr_cnt=1.
//  2. lw: ld_i=1, dmem_rdy high on 4th MEM cycle.
//     -> MEM lasts 4 cycles, then WB; instruction takes 8 cycles; RFWr pulses once.
//  3. sw: DMWr_i=1, dmem_rdy on 2nd MEM cycle.
//     -> DMWr=1 for both MEM cycles; PCWr on the 2nd; RFWr never high.
//  4. beq: RFWr_i=0.
//     -> retires from EXEC in 3 cycles.
//     - Also: except_i=1 -> state=6, mem_fault=1; rst -> state=0 next cycle.
//  5. Timeout: imem_rdy=0, MEM_WAIT_MAX=15.
//     -> FAULT after 16 FETCH cycles.
//     - Repeat with rdy on the 16th cycle -> DECODE, no fault.
//  6. Drop run during MEM of a lw.
//     -> lw completes via WB, then IDLE, imem_req=0.
//     - Also: preload instr_cnt at max, retire once -> 0.

Source files
------------

// File: rtl/mc_seq.sv
// rtl/mc_seq.sv - multi-cycle instruction sequencer between ctrl decode and datapath
// Steps FETCH/DECODE/EXEC/MEM/WB with bounded memory waits and single-retire write strobes.
module mc_seq #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_rdy,
    output logic             dmem_req,
    input  logic             dmem_rdy,
    input  logic             RFWr_i,
    input  logic             DMWr_i,
    input  logic             ld_i,
    input  logic             nop_i,
    input  logic             except_i,
    output logic             IRWr,
    output logic             PCWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic             mem_fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } st_t;

    localparam int            WW        = $clog2(MEM_WAIT_MAX + 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX);

    st_t               st;
    st_t               st_nxt;
    logic [WW-1:0]     wait_cnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic              retire;
    logic              timeout;

    assign state     = st;
    assign instr_cnt = cnt_q;
    assign mem_fault = fault_q;
    assign timeout   = (wait_cnt == WAIT_LAST);

    // Strobes are decoded from the current state and this cycle's handshakes,
    // so IRWr/PCWr land in the same cycle the rdy or retire decision is made.
    always_comb begin
        st_nxt   = st;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWr     = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        case (st)
            S_IDLE: begin
                if (run) st_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_rdy) begin
                    IRWr   = 1'b1;
                    st_nxt = S_DECODE;
                end else if (timeout) begin
                    st_nxt = S_FAULT;
                end
            end
            S_DECODE: st_nxt = S_EXEC;
            S_EXEC: begin
                if (except_i)            st_nxt = S_FAULT;
                else if (nop_i)          retire = 1'b1;
                else if (ld_i || DMWr_i) st_nxt = S_MEM;
                else if (RFWr_i)         st_nxt = S_WB;
                else                     retire = 1'b1;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                DMWr     = DMWr_i;
                if (dmem_rdy) begin
                    if (ld_i) st_nxt = S_WB;
                    else      retire = 1'b1;
                end else if (timeout) begin
                    st_nxt = S_FAULT;
                end
            end
            S_WB: begin
                RFWr   = 1'b1;
                retire = 1'b1;
            end
            S_FAULT: st_nxt = S_FAULT;
            default: st_nxt = S_FAULT;
        endcase
        if (retire) st_nxt = run ? S_FETCH : S_IDLE;
        PCWr = retire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            st <= st_nxt;
            // Any state change restarts the wait window; only a stalled FETCH/MEM advances it.
            if (st_nxt == st && (st == S_FETCH || st == S_MEM))
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
            if (st_nxt == S_FAULT) fault_q <= 1'b1;
        end
    end

endmodule
